// File: rtl/pa_dtu_pkg.sv
// pa_dtu_pkg: shared DTU state encoding and counter width default
package pa_dtu_pkg;
    localparam int DTU_CNT_WIDTH = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        REQ   = 2'b10,
        DONE  = 2'b11
    } dtu_state_e;
endpackage

// File: rtl/pa_dtu_evt_cnt.sv
// pa_dtu_evt_cnt: event counter with clear, increment and match/wrap detect
module pa_dtu_evt_cnt
    import pa_dtu_pkg::*;
#(
    parameter int CNT_WIDTH = DTU_CNT_WIDTH
) (
    input  logic                 cpuclk,
    input  logic                 cpurst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [CNT_WIDTH-1:0] match_val,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 hit,
    output logic                 wrap
);
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [CNT_WIDTH-1:0] eff_match;
    assign cnt_nxt   = cnt + 1'b1;
    // a programmed match of zero behaves as one
    assign eff_match = (match_val == '0) ? CNT_WIDTH'(1) : match_val;
    assign hit       = cnt_nxt == eff_match;
    assign wrap      = &cnt;
    always_ff @(posedge cpuclk) begin
        if (cpurst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt_nxt;
    end
endmodule

// File: rtl/pa_dtu_trig_evt_ctrl.sv
// pa_dtu_trig_evt_ctrl: counts synchronized trigger pulses and raises a held debug request on match
module pa_dtu_trig_evt_ctrl
    import pa_dtu_pkg::*;
#(
    parameter int CNT_WIDTH = DTU_CNT_WIDTH
) (
    input  logic                 cpuclk,
    input  logic                 cpurst,
    input  logic                 trig_pulse,
    input  logic                 cfg_en,
    input  logic                 cfg_clr,
    input  logic [CNT_WIDTH-1:0] cfg_match,
    input  logic                 dbg_ack,
    output logic                 dbg_req,
    output logic [CNT_WIDTH-1:0] evt_cnt,
    output logic                 hit_flag,
    output logic                 ovf_flag,
    output logic                 busy
);
    dtu_state_e state, state_nxt;
    logic cnt_clr, cnt_inc, cnt_hit, cnt_wrap, flag_clr, ovf_set;
    always_ff @(posedge cpuclk) begin
        state <= cpurst ? IDLE : state_nxt;
    end
    // cfg_clr outranks everything except the REQ handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = (!cfg_clr && cfg_en) ? COUNT : IDLE;
            COUNT: state_nxt = cfg_clr ? COUNT : !cfg_en ? IDLE : (trig_pulse && cnt_hit) ? REQ : COUNT;
            REQ:   state_nxt = dbg_ack ? (cfg_en ? DONE : IDLE) : REQ;
            DONE:  state_nxt = cfg_clr ? COUNT : !cfg_en ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        flag_clr = cfg_clr && (state != REQ);
        cnt_clr  = flag_clr || (state == IDLE && cfg_en);
        cnt_inc  = (state == COUNT) && !cfg_clr && cfg_en && trig_pulse;
        ovf_set  = !cfg_clr && trig_pulse && ((state == REQ) || (state == DONE) || (cnt_inc && cnt_wrap));
    end
    pa_dtu_evt_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_evt_cnt (
        .cpuclk    (cpuclk),
        .cpurst    (cpurst),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .match_val (cfg_match),
        .cnt       (evt_cnt),
        .hit       (cnt_hit),
        .wrap      (cnt_wrap)
    );
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            dbg_req  <= 1'b0;
            busy     <= 1'b0;
            hit_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            dbg_req  <= state_nxt == REQ;
            busy     <= (state_nxt == COUNT) || (state_nxt == REQ);
            hit_flag <= (hit_flag && !flag_clr) || (cnt_inc && cnt_hit);
            ovf_flag <= (ovf_flag && !cfg_clr) || ovf_set;
        end
    end
endmodule

// File: tb/tb_pa_dtu_trig_evt_ctrl.sv
// tb_pa_dtu_trig_evt_ctrl: scoreboard bench with directed and random stimulus against a rule-level model
module tb_pa_dtu_trig_evt_ctrl;
    localparam int W = 4;
    localparam int S_IDLE = 0, S_COUNT = 1, S_REQ = 2, S_DONE = 3;
    logic cpuclk = 1'b0;
    logic cpurst, trig_pulse, cfg_en, cfg_clr, dbg_ack;
    logic [W-1:0] cfg_match, evt_cnt;
    logic dbg_req, hit_flag, ovf_flag, busy;
    typedef struct {
        int           due;
        logic [W+3:0] exp;
    } exp_t;
    exp_t sb[$];
    int cyc = 0, n_vec = 0, n_err = 0;
    int m_st, m_cnt;
    bit m_hit, m_ovf;
    always #5 cpuclk = ~cpuclk;
    always @(posedge cpuclk) cyc <= cyc + 1;
    pa_dtu_trig_evt_ctrl #(.CNT_WIDTH(W)) u_dut (
        .cpuclk     (cpuclk),
        .cpurst     (cpurst),
        .trig_pulse (trig_pulse),
        .cfg_en     (cfg_en),
        .cfg_clr    (cfg_clr),
        .cfg_match  (cfg_match),
        .dbg_ack    (dbg_ack),
        .dbg_req    (dbg_req),
        .evt_cnt    (evt_cnt),
        .hit_flag   (hit_flag),
        .ovf_flag   (ovf_flag),
        .busy       (busy)
    );
    // one clock of stimulus; the model predicts the outputs seen after the coming edge
    task automatic step(input bit rst, input bit trig, input bit en, input bit clr, input bit ack, input int match);
        exp_t e;
        int tgt, n;
        cpurst = rst; trig_pulse = trig; cfg_en = en; cfg_clr = clr; dbg_ack = ack; cfg_match = W'(match);
        tgt = (match % (1 << W) == 0) ? 1 : match % (1 << W);
        if (rst) begin
            m_st = S_IDLE; m_cnt = 0; m_hit = 0; m_ovf = 0;
        end else begin
            case (m_st)
                S_IDLE: begin
                    if (clr) begin m_cnt = 0; m_hit = 0; m_ovf = 0; end
                    else if (en) begin m_st = S_COUNT; m_cnt = 0; end
                end
                S_COUNT: begin
                    if (clr) begin m_cnt = 0; m_hit = 0; m_ovf = 0; end
                    else if (!en) m_st = S_IDLE;
                    else if (trig) begin
                        n = (m_cnt + 1) % (1 << W);
                        if (n == 0) m_ovf = 1;
                        m_cnt = n;
                        if (n == tgt) begin m_hit = 1; m_st = S_REQ; end
                    end
                end
                S_REQ: begin
                    if (clr) m_ovf = 0;
                    else if (trig) m_ovf = 1;
                    if (ack) m_st = en ? S_DONE : S_IDLE;
                end
                default: begin
                    if (clr) begin m_st = S_COUNT; m_cnt = 0; m_hit = 0; m_ovf = 0; end
                    else begin
                        if (trig) m_ovf = 1;
                        if (!en) m_st = S_IDLE;
                    end
                end
            endcase
        end
        e.due = cyc + 1;
        e.exp = {m_st == S_REQ, m_st == S_COUNT || m_st == S_REQ, m_hit, m_ovf, W'(m_cnt)};
        sb.push_back(e);
        @(posedge cpuclk);
        #1;
    endtask
    always @(negedge cpuclk) begin : monitor
        exp_t e;
        logic [W+3:0] got;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            got = {dbg_req, busy, hit_flag, ovf_flag, evt_cnt};
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL out_vec cyc=%0d req/busy/hit/ovf/cnt got=%b required=%b", cyc, got, e.exp);
            end
        end
    end
    initial begin
        int match;
        bit en;
        repeat (2) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, i == 5 || i == 9 || i == 12, 1, 0, 0, 3);
        repeat (3) step(0, 0, 1, 0, 0, 3);
        step(0, 0, 1, 0, 1, 3);
        step(0, 0, 1, 0, 0, 3);
        step(0, 1, 1, 0, 0, 3);
        step(0, 0, 1, 1, 0, 3);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0, 5);
        repeat (2) step(0, 1, 1, 0, 0, 5);
        step(0, 1, 1, 1, 0, 5);
        step(0, 0, 1, 0, 0, 5);
        step(0, 1, 1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 9);
        repeat (5) step(0, 1, 1, 0, 0, 9);
        repeat (13) step(0, 1, 1, 0, 0, 2);
        step(0, 0, 1, 0, 1, 15);
        step(0, 0, 1, 1, 0, 15);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 0, 15);
        step(0, 1, 1, 1, 0, 15);
        step(1, 0, 1, 0, 0, 15);
        step(0, 0, 1, 0, 0, 15);
        match = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) match = $urandom_range(0, 15);
            en = $urandom_range(0, 9) != 0;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, en,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, match);
        end
        repeat (3) @(posedge cpuclk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
